// File: rtl/adam_axil_ram_arb_pkg.sv
// Shared types for the two-port AXI-Lite arbiter: FSM states and granted request type.
package adam_axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WB,
    RD,
    RB,
    PAUSED
  } state_t;

  typedef enum logic {
    WRITE,
    READ
  } req_type_t;

endpackage

// File: rtl/adam_axil_ram_arb_if.sv
// AXI-Lite bus bundle; master modport drives addresses/data, slave modport drives readys/responses.
interface adam_axil_ram_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_prot;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]            ar_prot;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport slave (
    input aw_addr, aw_prot, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

// File: rtl/adam_axil_ram_arb_rr_arb2.sv
// Two-input round-robin picker: the port other than `last` wins unless only `last` is requesting.
module adam_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

  always_comb begin
    gnt = ~last;
    if (!req[~last] && req[last]) gnt = last;
  end

endmodule

// File: rtl/adam_axil_ram_arb.sv
// Two-port AXI-Lite arbiter: one whole write or read at a time, round-robin grant,
// pause acknowledged only from an idle point.
module adam_axil_ram_arb
  import adam_axil_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pause_req,
  output logic                       pause_ack,
  adam_axil_ram_arb_if.slave         slv0,
  adam_axil_ram_arb_if.slave         slv1,
  adam_axil_ram_arb_if.master        mst
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t    state_reg, state_next;
  logic      last_reg, last_next;
  logic      gnt_reg, gnt_next;
  logic      aw_done_reg, aw_done_next;
  logic      w_done_reg, w_done_next;
  logic      pick;
  req_type_t pick_type;

  logic [1:0]            aw_valid_s, w_valid_s, ar_valid_s, b_ready_s, r_ready_s;
  logic [1:0]            wr_req, any_req;
  logic [ADDR_WIDTH-1:0] aw_addr_s [2];
  logic [ADDR_WIDTH-1:0] ar_addr_s [2];
  logic [2:0]            aw_prot_s [2];
  logic [2:0]            ar_prot_s [2];
  logic [DATA_WIDTH-1:0] w_data_s  [2];
  logic [STRB_WIDTH-1:0] w_strb_s  [2];

  assign aw_valid_s = {slv1.aw_valid, slv0.aw_valid};
  assign w_valid_s  = {slv1.w_valid,  slv0.w_valid};
  assign ar_valid_s = {slv1.ar_valid, slv0.ar_valid};
  assign b_ready_s  = {slv1.b_ready,  slv0.b_ready};
  assign r_ready_s  = {slv1.r_ready,  slv0.r_ready};
  assign aw_addr_s  = '{slv0.aw_addr, slv1.aw_addr};
  assign ar_addr_s  = '{slv0.ar_addr, slv1.ar_addr};
  assign aw_prot_s  = '{slv0.aw_prot, slv1.aw_prot};
  assign ar_prot_s  = '{slv0.ar_prot, slv1.ar_prot};
  assign w_data_s   = '{slv0.w_data,  slv1.w_data};
  assign w_strb_s   = '{slv0.w_strb,  slv1.w_strb};

  // Within a port a complete write (AW and W both valid) takes precedence over a read.
  assign wr_req    = aw_valid_s & w_valid_s;
  assign any_req   = wr_req | ar_valid_s;
  assign pick_type = wr_req[pick] ? WRITE : READ;

  adam_rr_arb2 u_rr (
    .req  (any_req),
    .last (last_reg),
    .gnt  (pick)
  );

  logic wr_st, wb_st, rd_st, rb_st, aw_fwd, w_fwd;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign wr_st  = (state_reg == WR);
  assign wb_st  = (state_reg == WB);
  assign rd_st  = (state_reg == RD);
  assign rb_st  = (state_reg == RB);
  assign aw_fwd = wr_st && !aw_done_reg;
  assign w_fwd  = wr_st && !w_done_reg;

  assign mst.aw_valid = aw_fwd && aw_valid_s[gnt_reg];
  assign mst.aw_addr  = aw_fwd ? aw_addr_s[gnt_reg] : '0;
  assign mst.aw_prot  = aw_fwd ? aw_prot_s[gnt_reg] : '0;
  assign mst.w_valid  = w_fwd && w_valid_s[gnt_reg];
  assign mst.w_data   = w_fwd ? w_data_s[gnt_reg] : '0;
  assign mst.w_strb   = w_fwd ? w_strb_s[gnt_reg] : '0;
  assign mst.b_ready  = wb_st && b_ready_s[gnt_reg];
  assign mst.ar_valid = rd_st && ar_valid_s[gnt_reg];
  assign mst.ar_addr  = rd_st ? ar_addr_s[gnt_reg] : '0;
  assign mst.ar_prot  = rd_st ? ar_prot_s[gnt_reg] : '0;
  assign mst.r_ready  = rb_st && r_ready_s[gnt_reg];

  assign aw_hs = mst.aw_valid && mst.aw_ready;
  assign w_hs  = mst.w_valid && mst.w_ready;
  assign b_hs  = mst.b_valid && mst.b_ready;
  assign ar_hs = mst.ar_valid && mst.ar_ready;
  assign r_hs  = mst.r_valid && mst.r_ready;

  logic [1:0]            sel, aw_ready_p, w_ready_p, ar_ready_p, b_valid_p, r_valid_p;
  logic [1:0]            b_resp_p [2];
  logic [1:0]            r_resp_p [2];
  logic [DATA_WIDTH-1:0] r_data_p [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign sel[gi]        = (gnt_reg == 1'(gi));
    assign aw_ready_p[gi] = aw_fwd && sel[gi] && mst.aw_ready;
    assign w_ready_p[gi]  = w_fwd && sel[gi] && mst.w_ready;
    assign ar_ready_p[gi] = rd_st && sel[gi] && mst.ar_ready;
    assign b_valid_p[gi]  = wb_st && sel[gi] && mst.b_valid;
    assign r_valid_p[gi]  = rb_st && sel[gi] && mst.r_valid;
    assign b_resp_p[gi]   = (wb_st && sel[gi]) ? mst.b_resp : '0;
    assign r_resp_p[gi]   = (rb_st && sel[gi]) ? mst.r_resp : '0;
    assign r_data_p[gi]   = (rb_st && sel[gi]) ? mst.r_data : '0;
  end

  assign slv0.aw_ready = aw_ready_p[0];
  assign slv0.w_ready  = w_ready_p[0];
  assign slv0.ar_ready = ar_ready_p[0];
  assign slv0.b_valid  = b_valid_p[0];
  assign slv0.b_resp   = b_resp_p[0];
  assign slv0.r_valid  = r_valid_p[0];
  assign slv0.r_resp   = r_resp_p[0];
  assign slv0.r_data   = r_data_p[0];
  assign slv1.aw_ready = aw_ready_p[1];
  assign slv1.w_ready  = w_ready_p[1];
  assign slv1.ar_ready = ar_ready_p[1];
  assign slv1.b_valid  = b_valid_p[1];
  assign slv1.b_resp   = b_resp_p[1];
  assign slv1.r_valid  = r_valid_p[1];
  assign slv1.r_resp   = r_resp_p[1];
  assign slv1.r_data   = r_data_p[1];

  // Ack drops combinationally with the request so the requester never sees a stale ack.
  assign pause_ack = (state_reg == PAUSED) && pause_req;

  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    gnt_next     = gnt_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    case (state_reg)
      IDLE: begin
        if (pause_req) begin
          state_next = PAUSED;
        end else if (|any_req) begin
          gnt_next   = pick;
          last_next  = pick;
          state_next = (pick_type == WRITE) ? WR : RD;
        end
      end
      WR: begin
        aw_done_next = aw_done_reg || aw_hs;
        w_done_next  = w_done_reg || w_hs;
        if (aw_done_next && w_done_next) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = WB;
        end
      end
      WB:      if (b_hs) state_next = IDLE;
      RD:      if (ar_hs) state_next = RB;
      RB:      if (r_hs) state_next = IDLE;
      PAUSED:  if (!pause_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      last_reg    <= 1'b1;
      gnt_reg     <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      gnt_reg     <= gnt_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
    end
  end

endmodule
